// File: rtl/dmem_responder.sv
// Data-memory responder: a byte-addressed little-endian store that answers each
// load/store after a fixed LATENCY. Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned accesses.
module dmem_responder #(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [3:0]  req_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [63:0] rdata_q;
   logic        err_q;
   logic [7:0]  mem [DEPTH_BYTES];

   logic          accept;
   logic          size_ok;
   logic [2:0]    lmask;
   logic [AW-1:0] base;
   logic [AW:0]   end_addr;
   logic          range_err;
   logic          err;
   logic [63:0]   rd;

   assign accept = req_valid && req_ready;

   always_comb begin
      size_ok = 1'b1;
      lmask   = 3'b000;
      case (req_size)
         4'd1:    lmask = 3'b000;
         4'd2:    lmask = 3'b001;
         4'd4:    lmask = 3'b011;
         4'd8:    lmask = 3'b111;
         default: size_ok = 1'b0;
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = |(req_addr[2:0] & lmask);
   assign base     = req_addr[AW-1:0];
`else
   // Misaligned addresses are silently aligned down to the transfer size.
   assign base     = {req_addr[AW-1:3], req_addr[2:0] & ~lmask};
`endif

   assign end_addr  = {1'b0, base} + (AW+1)'(req_size);
   assign range_err = (|req_addr[63:AW]) || (end_addr > (AW+1)'(DEPTH_BYTES));

`ifdef DMEM_MISALIGN_TRAP_EN
   assign err = !size_ok || range_err || misalign;
`else
   assign err = !size_ok || range_err;
`endif

   always_comb begin
      rd = '0;
      if (!err) begin
         for (int i = 0; i < 8; i++) begin
            if (i < int'(req_size)) rd[i*8 +: 8] = mem[base + AW'(i)];
         end
      end
   end

   // Stores commit at the accept edge; storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!reset && accept && req_write && !err) begin
         for (int i = 0; i < 8; i++) begin
            if (i < int'(req_size)) mem[base + AW'(i)] <= req_wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt <= 4'd1) state_nxt = RESP;
         RESP: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         cnt     <= 4'(LATENCY - 1);
         rdata_q <= req_write ? 64'd0 : rd;
         err_q   <= err;
      end else if (state == WAIT) begin
         cnt     <= cnt - 4'd1;
      end
   end

   always_comb begin
      req_ready  = (state == IDLE) && !reset;
      resp_valid = (state == RESP);
      resp_rdata = (state == RESP) ? rdata_q : 64'd0;
      resp_err   = (state == RESP) ? err_q : 1'b0;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table through the LATENCY=2 instance,
// hand sequences for backpressure, reset-in-flight and a LATENCY=1 instance.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic [3:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;

   logic        req_valid1, req_ready1, req_write1;
   logic [63:0] req_addr1, req_wdata1;
   logic [3:0]  req_size1;
   logic        resp_valid1, resp_ready1, resp_err1;
   logic [63:0] resp_rdata1;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
      .req_addr(req_addr1), .req_wdata(req_wdata1), .req_size(req_size1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1),
      .resp_rdata(resp_rdata1), .resp_err(resp_err1)
   );

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic        w;
      logic [63:0] addr;
      logic [63:0] wd;
      logic [3:0]  sz;
      logic [63:0] erd;
      logic        eerr;
   } vec_t;

   vec_t        vt [18];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] rd;
   logic        er;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // One full transaction on the LATENCY=2 instance; hold>0 keeps resp_ready low
   // for that many RESP cycles while a competing request is presented.
   task automatic xact(input string nm, input logic w, input logic [63:0] a,
                       input logic [63:0] wd, input logic [3:0] sz, input int hold,
                       output logic [63:0] rdo, output logic ero);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz;
      resp_ready = (hold == 0);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk({nm, "_accept_wait"}, 64'(n), 64'd0);
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b1; req_addr = 64'hFFFF_0000_0000_0003;
      req_wdata = '1; req_size = 4'd5;
      n = 1;
      while (!resp_valid && n < 20) begin
         chk({nm, "_ready_wait"}, 64'(req_ready), 64'd0);
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'd2);
      chk({nm, "_ready_resp"}, 64'(req_ready), 64'd0);
      rdo = resp_rdata;
      ero = resp_err;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd1016; req_size = 4'd8;
         @(negedge clk);
         chk({nm, "_hold_valid"}, 64'(resp_valid), 64'd1);
         chk({nm, "_hold_rdata"}, resp_rdata, rdo);
         chk({nm, "_hold_err"}, 64'(resp_err), 64'(ero));
         chk({nm, "_hold_ready"}, 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_resp_drop"}, 64'(resp_valid), 64'd0);
      chk({nm, "_idle_ready"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      vt[0]  = '{1'b1, 64'd16,   64'h0123456789ABCDEF, 4'd8, 64'h0, 1'b0};
      vt[1]  = '{1'b0, 64'd16,   64'h0, 4'd8, 64'h0123456789ABCDEF, 1'b0};
      vt[2]  = '{1'b0, 64'd17,   64'h0, 4'd1, 64'hCD, 1'b0};
      vt[3]  = '{1'b1, 64'd18,   64'hBEEF, 4'd2, 64'h0, 1'b0};
      vt[4]  = '{1'b1, 64'd16,   64'hAAAA, 4'd3, 64'h0, 1'b1};
      vt[5]  = '{1'b0, 64'd16,   64'h0, 4'd8, 64'h01234567BEEFCDEF, 1'b0};
      vt[6]  = '{1'b0, 64'd20,   64'h0, 4'd4, 64'h01234567, 1'b0};
      vt[7]  = '{1'b0, 64'd16,   64'h0, 4'd2, 64'hCDEF, 1'b0};
      vt[8]  = '{1'b1, 64'd1016, 64'h1122334455667788, 4'd8, 64'h0, 1'b0};
      vt[9]  = '{1'b1, 64'd1024, 64'hFF, 4'd1, 64'h0, 1'b1};
      vt[10] = '{1'b0, 64'd16,   64'h0, 4'd3, 64'h0, 1'b1};
      vt[11] = '{1'b1, 64'h8000_0000_0000_0010, 64'hDEAD, 4'd8, 64'h0, 1'b1};
      vt[12] = '{1'b0, 64'd1016, 64'h0, 4'd8, 64'h1122334455667788, 1'b0};
      vt[13] = '{1'b0, 64'd1023, 64'h0, 4'd1, 64'h11, 1'b0};
      vt[14] = '{1'b0, 64'd17,   64'h0, 4'd8, TRAP ? 64'h0 : 64'h01234567BEEFCDEF, TRAP};
      vt[15] = '{1'b0, 64'd19,   64'h0, 4'd2, TRAP ? 64'h0 : 64'hBEEF, TRAP};
      vt[16] = '{1'b1, 64'd17,   64'h9999, 4'd8, 64'h0, TRAP};
      vt[17] = '{1'b0, 64'd16,   64'h0, 4'd8, TRAP ? 64'h01234567BEEFCDEF : 64'h9999, 1'b0};

      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_size = 4'd1;
      resp_ready = 1'b1;
      req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_size1 = 4'd1;
      resp_ready1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_err", 64'(resp_err), 64'd0);
      reset = 1'b0;
      #1;
      chk("rst_release_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 18; i++) begin
         xact($sformatf("v%0d", i), vt[i].w, vt[i].addr, vt[i].wd, vt[i].sz, 0, rd, er);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].erd);
         chk($sformatf("v%0d_err", i), 64'(er), 64'(vt[i].eerr));
      end

      // Backpressure: response frozen for 5 cycles with a competing request.
      xact("hold", 1'b0, 64'd1016, 64'h0, 4'd8, 5, rd, er);
      chk("hold_rdata", rd, 64'h1122334455667788);
      chk("hold_err", 64'(er), 64'd0);

      // Reset while a load is waiting: its response must never appear.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd16; req_size = 4'd8;
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      chk("midrst_valid", 64'(resp_valid), 64'd0);
      reset = 1'b0;
      #1;
      chk("midrst_release_ready", 64'(req_ready), 64'd1);
      begin
         int seen;
         seen = 0;
         repeat (6) begin @(negedge clk); if (resp_valid) seen++; end
         chk("midrst_no_resp", 64'(seen), 64'd0);
      end

      // A store committed at accept survives a reset during its wait.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd40; req_wdata = 64'h5A; req_size = 4'd1;
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      xact("keep", 1'b0, 64'd40, 64'h0, 4'd1, 0, rd, er);
      chk("keep_rdata", rd, 64'h5A);
      chk("keep_err", 64'(er), 64'd0);

      // LATENCY=1 instance: response visible the cycle after accept.
      @(negedge clk);
      chk("l1_ready", 64'(req_ready1), 64'd1);
      req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 64'd8; req_wdata1 = 64'h77; req_size1 = 4'd1;
      @(negedge clk);
      req_valid1 = 1'b0;
      chk("l1_store_valid", 64'(resp_valid1), 64'd1);
      chk("l1_store_err", 64'(resp_err1), 64'd0);
      @(negedge clk);
      chk("l1_store_drop", 64'(resp_valid1), 64'd0);
      chk("l1_idle_ready", 64'(req_ready1), 64'd1);
      req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 64'd8; req_size1 = 4'd1;
      @(negedge clk);
      req_valid1 = 1'b0;
      chk("l1_load_valid", 64'(resp_valid1), 64'd1);
      chk("l1_load_rdata", resp_rdata1, 64'h77);
      @(negedge clk);
      chk("l1_load_drop", 64'(resp_valid1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
